// File: rtl/rv_defs_pkg.sv
// Shared RV32I definitions for the ID stage: opcodes, funct3 codes, ALU op encodings,
// the control bundle carried in ID/EX, and the immediate extraction helper.
package rv_defs_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] ALU_OP_ADD = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB = 4'b1000;
  localparam logic [3:0] ALU_OP_SRL = 4'b0101;
  localparam logic [3:0] ALU_OP_SRA = 4'b1101;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_J
  } imm_fmt_e;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic alu_src;
    logic link;
    logic illegal;
  } ctrl_t;

  // Sign-extended immediate; B and J keep their implicit zero LSB (byte offsets).
  function automatic logic [31:0] imm_decode(input logic [31:0] instr, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// Register file with two asynchronous read ports and one clocked write port; x0 is hardwired 0.
// Optional ID_WB_BYPASS_EN: a read matching the active writeback returns wb_data in the same cycle.
module register_file
  import rv_defs_pkg::*;
#(
  parameter int NUM_REGS   = 32,
  parameter int WIDTH_DATA = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4:0]            rs1_addr,
  input  logic [4:0]            rs2_addr,
  output logic [WIDTH_DATA-1:0] rs1_data,
  output logic [WIDTH_DATA-1:0] rs2_data,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [WIDTH_DATA-1:0] wb_data
);

  logic [WIDTH_DATA-1:0] regs [NUM_REGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_we && wb_rd != 5'd0) begin
      regs[wb_rd] <= wb_data;
    end
  end

  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs[rs1_addr];
`ifdef ID_WB_BYPASS_EN
      if (wb_we && wb_rd == rs1_addr) rs1_data = wb_data;
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = regs[rs2_addr];
`ifdef ID_WB_BYPASS_EN
      if (wb_we && wb_rd == rs2_addr) rs2_data = wb_data;
`endif
    end
  end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode, hazard detection, BEQ/BNE/JAL resolution and the ID/EX pipeline register.
// Optional ID_WB_BYPASS_EN (in register_file) forwards same-cycle writeback into operand reads.
module instruction_decode
  import rv_defs_pkg::*;
#(
  parameter int WIDTH_PC   = 32,
  parameter int WIDTH_DATA = 32,
  parameter int NUM_REGS   = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WIDTH_PC-1:0]   pc_in,
  input  logic [31:0]           instruction_in,
  input  logic                  wb_we,
  input  logic [4:0]            wb_rd,
  input  logic [WIDTH_DATA-1:0] wb_data,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic [4:0]            ex_rd,
  input  logic                  mem_mem_read,
  input  logic [4:0]            mem_rd,
  output logic                  stall,
  output logic                  branch_taken,
  output logic [WIDTH_PC-1:0]   pc_branch_out,
  output logic [WIDTH_PC-1:0]   idex_pc,
  output logic [WIDTH_DATA-1:0] idex_rs1_data,
  output logic [WIDTH_DATA-1:0] idex_rs2_data,
  output logic [WIDTH_DATA-1:0] idex_imm,
  output logic [4:0]            idex_rs1,
  output logic [4:0]            idex_rs2,
  output logic [4:0]            idex_rd,
  output logic [3:0]            idex_alu_op,
  output logic                  idex_reg_write,
  output logic                  idex_mem_read,
  output logic                  idex_mem_write,
  output logic                  idex_mem_to_reg,
  output logic                  idex_alu_src,
  output logic                  idex_link,
  output logic                  idex_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;

  assign opcode = instruction_in[6:0];
  assign rd     = instruction_in[11:7];
  assign funct3 = instruction_in[14:12];
  assign rs1    = instruction_in[19:15];
  assign rs2    = instruction_in[24:20];

  logic [WIDTH_DATA-1:0] rs1_raw, rs2_raw;

  register_file #(
    .NUM_REGS  (NUM_REGS),
    .WIDTH_DATA(WIDTH_DATA)
  ) u_register_file (
    .clock   (clock),
    .reset   (reset),
    .rs1_addr(rs1),
    .rs2_addr(rs2),
    .rs1_data(rs1_raw),
    .rs2_data(rs2_raw),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  ctrl_t    ctrl;
  imm_fmt_e fmt;
  logic [3:0] alu_op;
  logic use_rs1, use_rs2, is_branch, is_jal;

  always_comb begin
    ctrl      = '0;
    fmt       = FMT_NONE;
    alu_op    = ALU_OP_ADD;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    case (opcode)
      OPC_OP: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        alu_op         = {instruction_in[30], funct3};
        ctrl.reg_write = (rd != 5'd0);
      end
      OPC_OP_IMM: begin
        use_rs1        = 1'b1;
        fmt            = FMT_I;
        // bit 30 is part of the immediate except for shift-right, where it selects SRAI
        alu_op         = {(funct3 == F3_SR) & instruction_in[30], funct3};
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = (rd != 5'd0);
      end
      OPC_LOAD: begin
        if (funct3 == F3_LW) begin
          use_rs1         = 1'b1;
          fmt             = FMT_I;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.alu_src    = 1'b1;
          ctrl.reg_write  = (rd != 5'd0);
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_STORE: begin
        use_rs1        = 1'b1;
        use_rs2        = 1'b1;
        fmt            = FMT_S;
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OPC_BRANCH: begin
        if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
          use_rs1   = 1'b1;
          use_rs2   = 1'b1;
          fmt       = FMT_B;
          is_branch = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OPC_JAL: begin
        fmt            = FMT_J;
        is_jal         = 1'b1;
        ctrl.link      = 1'b1;
        ctrl.reg_write = (rd != 5'd0);
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  logic [WIDTH_DATA-1:0]        imm;
  logic signed [WIDTH_DATA-1:0] imm_word;
  logic                         squash_q;
  logic                         ex_hit, mem_hit, cond_true, bubble;

  assign imm      = WIDTH_DATA'(imm_decode(instruction_in, fmt));
  // pc counts words, so the byte offset is scaled down arithmetically
  assign imm_word = $signed(imm) >>> 2;

  assign ex_hit  = (ex_rd != 5'd0) &&
                   ((use_rs1 && ex_rd == rs1) || (use_rs2 && ex_rd == rs2));
  assign mem_hit = (mem_rd != 5'd0) &&
                   ((use_rs1 && mem_rd == rs1) || (use_rs2 && mem_rd == rs2));

  assign cond_true = (funct3 == F3_BNE) ? (rs1_raw != rs2_raw) : (rs1_raw == rs2_raw);

  assign stall = ~squash_q &
                 ((ex_mem_read & ex_hit) |
                  (is_branch & ((ex_reg_write & ex_hit) | (mem_mem_read & mem_hit))));

  assign branch_taken  = ~squash_q & ~stall & (is_jal | (is_branch & cond_true));
  assign pc_branch_out = pc_in + WIDTH_PC'(imm_word);

  // JAL still enters EX to perform its link write; a taken conditional branch does not
  assign bubble = squash_q | stall | ctrl.illegal | (is_branch & branch_taken);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      squash_q        <= 1'b0;
      idex_pc         <= '0;
      idex_rs1_data   <= '0;
      idex_rs2_data   <= '0;
      idex_imm        <= '0;
      idex_rs1        <= '0;
      idex_rs2        <= '0;
      idex_rd         <= '0;
      idex_alu_op     <= '0;
      idex_reg_write  <= 1'b0;
      idex_mem_read   <= 1'b0;
      idex_mem_write  <= 1'b0;
      idex_mem_to_reg <= 1'b0;
      idex_alu_src    <= 1'b0;
      idex_link       <= 1'b0;
      idex_illegal    <= 1'b0;
    end else begin
      squash_q <= branch_taken;
      if (bubble) begin
        idex_pc         <= '0;
        idex_rs1_data   <= '0;
        idex_rs2_data   <= '0;
        idex_imm        <= '0;
        idex_rs1        <= '0;
        idex_rs2        <= '0;
        idex_rd         <= '0;
        idex_alu_op     <= '0;
        idex_reg_write  <= 1'b0;
        idex_mem_read   <= 1'b0;
        idex_mem_write  <= 1'b0;
        idex_mem_to_reg <= 1'b0;
        idex_alu_src    <= 1'b0;
        idex_link       <= 1'b0;
        idex_illegal    <= ctrl.illegal & ~squash_q;
      end else begin
        idex_pc         <= pc_in;
        idex_rs1_data   <= use_rs1 ? rs1_raw : '0;
        idex_rs2_data   <= use_rs2 ? rs2_raw : '0;
        idex_imm        <= imm;
        idex_rs1        <= use_rs1 ? rs1 : 5'd0;
        idex_rs2        <= use_rs2 ? rs2 : 5'd0;
        idex_rd         <= ctrl.reg_write ? rd : 5'd0;
        idex_alu_op     <= alu_op;
        idex_reg_write  <= ctrl.reg_write;
        idex_mem_read   <= ctrl.mem_read;
        idex_mem_write  <= ctrl.mem_write;
        idex_mem_to_reg <= ctrl.mem_to_reg;
        idex_alu_src    <= ctrl.alu_src;
        idex_link       <= ctrl.link;
        idex_illegal    <= 1'b0;
      end
    end
  end

endmodule
